// File: rtl/solver_sequencer.sv
// solver_sequencer: escape-time solver controller.
// Walks the limb-serial datapath through an optional abs(z) pass (Burning Ship mode),
// the multiply-accumulate partial sweep, a pipeline flush and a divergence check, then
// holds the result on a valid/ready handshake until the consumer accepts it.
// Optional feature: define SOLVER_SEQ_CYCLE_CNT_EN to add a saturating cycle_count output.
module solver_sequencer #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int ITER_BITS       = 16,
  parameter int FLUSH_WAIT      = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       wr_en,
  input  logic                       wr_num_limbs_en,
  input  logic [LIMB_INDEX_BITS-1:0] num_limbs_data,
  input  logic                       wr_iter_lim_en,
  input  logic [ITER_BITS-1:0]       iter_lim_data,
  input  logic                       mode_abs,
  input  logic                       start,
  output logic                       busy,
  output logic                       c_wr_en,
  output logic [1:0]                 op_sel,
  output logic [LIMB_INDEX_BITS-1:0] limb_ind,
  output logic [LIMB_INDEX_BITS-1:0] zre_ind,
  output logic [LIMB_INDEX_BITS-1:0] zim_ind,
  output logic                       flip,
  output logic                       diag,
  output logic [1:0]                 zre_acc_sel,
  output logic [1:0]                 zim_acc_sel,
  output logic                       im_neg,
  output logic                       z_wr_en,
  input  logic                       zre_sign,
  input  logic                       zim_sign,
  input  logic                       diverged,
  output logic                       result_valid,
  input  logic                       result_ready,
  output logic [ITER_BITS-1:0]       iteration_count,
  output logic                       escaped
`ifdef SOLVER_SEQ_CYCLE_CNT_EN
  ,
  output logic [31:0]                cycle_count
`endif
);

  localparam int FlushCntBits = (FLUSH_WAIT < 1) ? 1 : $clog2(FLUSH_WAIT + 1);

  typedef enum logic [2:0] {
    IDLE, ABS, ABS_FLUSH, ITER, ITER_FLUSH, CHECK, DONE
  } state_e;

  state_e                     state_q;
  logic [LIMB_INDEX_BITS-1:0] numLimbs_q;
  logic [ITER_BITS-1:0]       iterLim_q;
  logic                       modeAbs_q;
  logic                       reSign_q;
  logic                       imSign_q;
  logic [ITER_BITS-1:0]       count_q;
  logic                       escaped_q;
  logic [LIMB_INDEX_BITS-1:0] limb_q;
  logic [LIMB_INDEX_BITS-1:0] part_q;
  logic                       flip_q;
  logic [FlushCntBits-1:0]    flushCnt_q;

  logic [LIMB_INDEX_BITS-1:0] numLimbs_d;
  logic [LIMB_INDEX_BITS-1:0] topLimb;
  logic [LIMB_INDEX_BITS-1:0] iterRe;
  logic [LIMB_INDEX_BITS-1:0] iterIm;
  logic                       inAbs;
  logic                       inIter;
  logic                       absTop;

  // A zero limb count would leave nothing to walk, so it is stored as a single limb.
  assign numLimbs_d = (num_limbs_data == '0) ? LIMB_INDEX_BITS'(1) : num_limbs_data;
  assign topLimb    = numLimbs_q - LIMB_INDEX_BITS'(1);

  // Main sequencer: config capture in IDLE, limb/partial walk, flush timing and the check decision.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      numLimbs_q <= LIMB_INDEX_BITS'(1);
      iterLim_q  <= '0;
      modeAbs_q  <= 1'b0;
      reSign_q   <= 1'b0;
      imSign_q   <= 1'b0;
      count_q    <= '0;
      escaped_q  <= 1'b0;
      limb_q     <= '0;
      part_q     <= '0;
      flip_q     <= 1'b0;
      flushCnt_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_num_limbs_en) numLimbs_q <= numLimbs_d;
          if (wr_iter_lim_en)  iterLim_q  <= iter_lim_data;
          if (start) begin
            count_q   <= '0;
            escaped_q <= 1'b0;
            reSign_q  <= 1'b0;
            imSign_q  <= 1'b0;
            modeAbs_q <= mode_abs;
            limb_q    <= topLimb;
            part_q    <= '0;
            flip_q    <= 1'b0;
            state_q   <= mode_abs ? ABS : ITER;
          end
        end
        ABS: begin
          if (limb_q == '0) begin
            flushCnt_q <= '0;
            state_q    <= ABS_FLUSH;
          end else begin
            limb_q <= limb_q - LIMB_INDEX_BITS'(1);
          end
        end
        ABS_FLUSH: begin
          if (flushCnt_q == FlushCntBits'(FLUSH_WAIT)) begin
            limb_q  <= topLimb;
            part_q  <= '0;
            flip_q  <= 1'b0;
            state_q <= ITER;
          end else begin
            flushCnt_q <= flushCnt_q + FlushCntBits'(1);
          end
        end
        ITER: begin
          if (!flip_q) begin
            flip_q <= 1'b1;
          end else begin
            flip_q <= 1'b0;
            if (part_q == (limb_q >> 1)) begin
              part_q <= '0;
              if (limb_q == '0) begin
                flushCnt_q <= '0;
                state_q    <= ITER_FLUSH;
              end else begin
                limb_q <= limb_q - LIMB_INDEX_BITS'(1);
              end
            end else begin
              part_q <= part_q + LIMB_INDEX_BITS'(1);
            end
          end
        end
        ITER_FLUSH: begin
          if (flushCnt_q == FlushCntBits'(FLUSH_WAIT)) begin
            state_q <= CHECK;
          end else begin
            flushCnt_q <= flushCnt_q + FlushCntBits'(1);
          end
        end
        CHECK: begin
          reSign_q <= zre_sign;
          imSign_q <= zim_sign;
          if (diverged) begin
            escaped_q <= 1'b1;
            state_q   <= DONE;
          end else if (count_q == iterLim_q) begin
            escaped_q <= 1'b0;
            state_q   <= DONE;
          end else begin
            count_q <= count_q + ITER_BITS'(1);
            limb_q  <= topLimb;
            part_q  <= '0;
            flip_q  <= 1'b0;
            state_q <= modeAbs_q ? ABS : ITER;
          end
        end
        DONE: begin
          if (result_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign inAbs  = (state_q == ABS);
  assign inIter = (state_q == ITER);
  assign absTop = (limb_q == topLimb);
  assign iterRe = flip_q ? part_q : limb_q - part_q;
  assign iterIm = flip_q ? limb_q - part_q : part_q;

  assign busy            = (state_q != IDLE);
  assign c_wr_en         = (state_q == IDLE) & wr_en;
  assign op_sel          = inAbs ? 2'd2 : (inIter ? 2'd1 : 2'd0);
  assign limb_ind        = (inAbs | inIter) ? limb_q : '0;
  assign zre_ind         = inAbs ? limb_q : (inIter ? iterRe : '0);
  assign zim_ind         = inAbs ? limb_q : (inIter ? iterIm : '0);
  assign flip            = inIter & flip_q;
  assign diag            = inIter & (iterRe == iterIm);
  assign zre_acc_sel     = (inAbs & reSign_q) ? (absTop ? 2'd1 : 2'd2) : 2'd0;
  assign zim_acc_sel     = (inAbs & imSign_q) ? (absTop ? 2'd1 : 2'd2) : 2'd0;
  assign im_neg          = inIter & (reSign_q ^ imSign_q);
  assign z_wr_en         = inAbs | inIter;
  assign result_valid    = (state_q == DONE);
  assign iteration_count = count_q;
  assign escaped         = escaped_q;

`ifdef SOLVER_SEQ_CYCLE_CNT_EN
  logic [31:0] cycleCnt_q;
  logic [31:0] cycleCnt_d;

  // Next cycle count: cleared by an accepted start, advances in every working state, saturates.
  always_comb begin
    cycleCnt_d = cycleCnt_q;
    if (state_q == IDLE) begin
      if (start) cycleCnt_d = '0;
    end else if ((state_q != DONE) && (cycleCnt_q != 32'hFFFF_FFFF)) begin
      cycleCnt_d = cycleCnt_q + 32'd1;
    end
  end

  // Cycle counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cycleCnt_q <= '0;
    else          cycleCnt_q <= cycleCnt_d;
  end

  assign cycle_count = cycleCnt_q;
`else
  // No cycle counter in this build; sequencing is unchanged.
`endif

endmodule

// File: tb/tb_solver_sequencer.sv
// tb_solver_sequencer: randomized scoreboard bench for solver_sequencer.
// A loop-level reference model expands each solve into the expected per-cycle output
// stream and the final result; a negedge monitor pops and compares independently.
module tb_solver_sequencer;
  localparam int LIB = 6;
  localparam int IB  = 16;
  localparam int FW  = 4;

  logic clock = 1'b0;
  logic reset_n;
  logic wr_en, wr_num_limbs_en, wr_iter_lim_en, mode_abs, start;
  logic [LIB-1:0] num_limbs_data;
  logic [IB-1:0]  iter_lim_data;
  logic busy, c_wr_en, flip, diag, im_neg, z_wr_en, result_valid, escaped;
  logic [1:0] op_sel, zre_acc_sel, zim_acc_sel;
  logic [LIB-1:0] limb_ind, zre_ind, zim_ind;
  logic zre_sign, zim_sign, diverged, result_ready;
  logic [IB-1:0] iteration_count;
`ifdef SOLVER_SEQ_CYCLE_CNT_EN
  logic [31:0] cycle_count;
`endif

  always #5 clock = ~clock;

  solver_sequencer #(.LIMB_INDEX_BITS(LIB), .ITER_BITS(IB), .FLUSH_WAIT(FW)) dut (
    .clock(clock), .reset_n(reset_n), .wr_en(wr_en), .wr_num_limbs_en(wr_num_limbs_en),
    .num_limbs_data(num_limbs_data), .wr_iter_lim_en(wr_iter_lim_en), .iter_lim_data(iter_lim_data),
    .mode_abs(mode_abs), .start(start), .busy(busy), .c_wr_en(c_wr_en), .op_sel(op_sel),
    .limb_ind(limb_ind), .zre_ind(zre_ind), .zim_ind(zim_ind), .flip(flip), .diag(diag),
    .zre_acc_sel(zre_acc_sel), .zim_acc_sel(zim_acc_sel), .im_neg(im_neg), .z_wr_en(z_wr_en),
    .zre_sign(zre_sign), .zim_sign(zim_sign), .diverged(diverged), .result_valid(result_valid),
    .result_ready(result_ready), .iteration_count(iteration_count), .escaped(escaped)
`ifdef SOLVER_SEQ_CYCLE_CNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  typedef struct packed {
    logic [1:0]     opSel;
    logic [LIB-1:0] limb;
    logic [LIB-1:0] zre;
    logic [LIB-1:0] zim;
    logic           flip;
    logic           diag;
    logic [1:0]     zreAcc;
    logic [1:0]     zimAcc;
    logic           imNeg;
    logic           zWr;
    logic           cWr;
  } step_t;

  typedef struct packed {
    logic isCheck;
    logic div;
    logic sRe;
    logic sIm;
  } drv_t;

  typedef struct packed {
    logic [IB-1:0] count;
    logic          esc;
    logic [31:0]   cycles;
  } res_t;

  step_t expStepQ[$];
  drv_t  drvQ[$];
  res_t  expResQ[$];
  int    reSeq[64];
  int    imSeq[64];
  int    cfgNl = 1;
  int    cfgLim = 0;
  int    firstIterFlush = -1;
  int    checks = 0;
  int    errors = 0;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Queue one expected output cycle plus random don't-care inputs for it.
  function automatic void pushStep(input int op, input int limb, input int zre, input int zim,
                                   input int fl, input int zreAcc, input int zimAcc, input int imNeg);
    step_t s;
    drv_t  d;
    s.opSel  = 2'(op);
    s.limb   = LIB'(limb);
    s.zre    = LIB'(zre);
    s.zim    = LIB'(zim);
    s.flip   = 1'(fl);
    s.diag   = (op == 1) && (zre == zim);
    s.zreAcc = 2'(zreAcc);
    s.zimAcc = 2'(zimAcc);
    s.imNeg  = 1'(imNeg);
    s.zWr    = (op != 0);
    s.cWr    = 1'b0;
    expStepQ.push_back(s);
    d.isCheck = 1'b0;
    d.div     = 1'($urandom_range(0, 1));
    d.sRe     = 1'($urandom_range(0, 1));
    d.sIm     = 1'($urandom_range(0, 1));
    drvQ.push_back(d);
  endfunction

  function automatic void pushFlush();
    for (int i = 0; i <= FW; i++) pushStep(0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  // Reference model: one solve expanded from the escape-time rules with plain loops.
  function automatic void buildModel(input int nl, input int lim, input bit mode, input int divAt);
    int   k = 0;
    int   base = expStepQ.size();
    bit   re = 0;
    bit   im = 0;
    res_t r;
    drv_t d;
    firstIterFlush = -1;
    while (1) begin
      if (mode) begin
        for (int l = nl - 1; l >= 0; l--) begin
          pushStep(2, l, l, l, 0, re ? ((l == nl - 1) ? 1 : 2) : 0,
                   im ? ((l == nl - 1) ? 1 : 2) : 0, 0);
        end
        pushFlush();
      end
      for (int l = nl - 1; l >= 0; l--)
        for (int p = 0; p <= l / 2; p++)
          for (int f = 0; f < 2; f++)
            pushStep(1, l, f ? p : l - p, f ? l - p : p, f, 0, 0, int'(re ^ im));
      if (firstIterFlush < 0) firstIterFlush = expStepQ.size() - base;
      pushFlush();
      pushStep(0, 0, 0, 0, 0, 0, 0, 0);
      d = drvQ.pop_back();
      d.isCheck = 1'b1;
      d.div = (k == divAt);
      d.sRe = 1'(reSeq[k]);
      d.sIm = 1'(imSeq[k]);
      drvQ.push_back(d);
      re = d.sRe;
      im = d.sIm;
      if (d.div || k == lim) begin
        r.count  = IB'(k);
        r.esc    = d.div;
        r.cycles = 32'(expStepQ.size() - base);
        expResQ.push_back(r);
        break;
      end
      k++;
    end
  endfunction

  // Every output must read zero while reset is held.
  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 0);
    checkOutput({tag, "_cwr"}, 64'(c_wr_en), 0);
    checkOutput({tag, "_opsel"}, 64'(op_sel), 0);
    checkOutput({tag, "_idx"}, 64'({limb_ind, zre_ind, zim_ind}), 0);
    checkOutput({tag, "_flags"}, 64'({flip, diag, im_neg, z_wr_en}), 0);
    checkOutput({tag, "_acc"}, 64'({zre_acc_sel, zim_acc_sel}), 0);
    checkOutput({tag, "_valid"}, 64'(result_valid), 0);
    checkOutput({tag, "_result"}, 64'({iteration_count, escaped}), 0);
`ifdef SOLVER_SEQ_CYCLE_CNT_EN
    checkOutput({tag, "_cycles"}, 64'(cycle_count), 0);
`endif
  endtask

  // Drive one complete solve (optionally reset mid ITER_FLUSH) and queue its expectations.
  task automatic applyStimulus(input int nlData, input bit writeCfg, input int lim, input bit mode,
                               input int divAt, input int readyDelay, input bit resetMid,
                               input bit forceSigns);
    drv_t d;
    int   n;
    @(negedge clock);
    if (writeCfg) begin
      wr_num_limbs_en = 1'b1;
      num_limbs_data  = LIB'(nlData);
      wr_iter_lim_en  = 1'b1;
      iter_lim_data   = IB'(lim);
      @(negedge clock);
      wr_num_limbs_en = 1'b0;
      wr_iter_lim_en  = 1'b0;
      cfgNl  = (nlData == 0) ? 1 : nlData;
      cfgLim = lim;
    end
    for (int i = 0; i < 64; i++) begin
      reSeq[i] = int'($urandom_range(0, 1));
      imSeq[i] = int'($urandom_range(0, 1));
    end
    if (forceSigns) begin
      reSeq[0] = 1;
      imSeq[0] = 0;
    end
    buildModel(cfgNl, cfgLim, mode, divAt);
    start    = 1'b1;
    mode_abs = mode;
    n = drvQ.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      d = drvQ.pop_front();
      start           = 1'($urandom_range(0, 1));
      mode_abs        = 1'($urandom_range(0, 1));
      wr_en           = 1'($urandom_range(0, 1));
      wr_num_limbs_en = 1'($urandom_range(0, 1));
      num_limbs_data  = LIB'($urandom_range(1, 63));
      wr_iter_lim_en  = 1'($urandom_range(0, 1));
      iter_lim_data   = IB'($urandom_range(0, 65535));
      diverged = d.div;
      zre_sign = d.sRe;
      zim_sign = d.sIm;
      if (resetMid && i == firstIterFlush) begin
        wr_en = 1'b0;
        #2 reset_n = 1'b0;
        #1 checkResetOutputs("midReset");
        expStepQ.delete();
        expResQ.delete();
        drvQ.delete();
        start = 1'b0;
        wr_num_limbs_en = 1'b0;
        wr_iter_lim_en = 1'b0;
        cfgNl = 1;
        cfgLim = 0;
        @(negedge clock);
        reset_n = 1'b1;
        return;
      end
    end
    @(negedge clock);
    start = 1'b0;
    wr_en = 1'b0;
    wr_num_limbs_en = 1'b0;
    wr_iter_lim_en = 1'b0;
    result_ready = 1'b0;
    for (int j = 0; j < readyDelay; j++) begin
      start = 1'($urandom_range(0, 1));
      @(negedge clock);
    end
    result_ready = 1'b1;
    @(negedge clock);
    result_ready = 1'b0;
    start = 1'b0;
    @(negedge clock);
  endtask

  // Monitor: compares each working cycle and each held result against the scoreboard.
  always @(negedge clock) begin : monitor
    step_t act;
    step_t exp;
    res_t  r;
    logic  prevValid;
    if (!reset_n) begin
      prevValid = 1'b0;
    end else begin
      if (prevValid && !result_valid && expResQ.size() > 0) void'(expResQ.pop_front());
      if (busy && !result_valid) begin
        act.opSel = op_sel;   act.limb = limb_ind; act.zre = zre_ind; act.zim = zim_ind;
        act.flip = flip;      act.diag = diag;     act.zreAcc = zre_acc_sel;
        act.zimAcc = zim_acc_sel; act.imNeg = im_neg; act.zWr = z_wr_en; act.cWr = c_wr_en;
        if (expStepQ.size() == 0) begin
          checkOutput("unexpectedBusyCycle", 64'(act), 0);
          checkOutput("unexpectedBusy", 64'(busy), 0);
        end else begin
          exp = expStepQ.pop_front();
          checkOutput("step", 64'(act), 64'(exp));
        end
      end else if (result_valid) begin
        if (expResQ.size() == 0) begin
          checkOutput("unexpectedResult", 64'(result_valid), 0);
        end else begin
          r = expResQ[0];
          checkOutput("resultCount", 64'(iteration_count), 64'(r.count));
          checkOutput("resultEscaped", 64'(escaped), 64'(r.esc));
          checkOutput("doneQuiet", 64'({busy, op_sel, z_wr_en}), 64'({1'b1, 2'b00, 1'b0}));
`ifdef SOLVER_SEQ_CYCLE_CNT_EN
          checkOutput("cycleCount", 64'(cycle_count), 64'(r.cycles));
`endif
        end
      end else begin
        checkOutput("idleQuiet", 64'({op_sel, z_wr_en, result_valid}), 0);
      end
      prevValid = result_valid;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired before the run completed");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n = 1'b0;
    wr_en = 1'b0; wr_num_limbs_en = 1'b0; wr_iter_lim_en = 1'b0;
    num_limbs_data = '0; iter_lim_data = '0; mode_abs = 1'b0; start = 1'b0;
    zre_sign = 1'b0; zim_sign = 1'b0; diverged = 1'b0; result_ready = 1'b0;
    #12 checkResetOutputs("reset");
    @(negedge clock);
    reset_n = 1'b1;
    #1 wr_en = 1'b1;
    #1 checkOutput("cWrIdle", 64'(c_wr_en), 1);
    wr_en = 1'b0;
    $display("[TB] default config solve");
    applyStimulus(0, 1'b0, 0, 1'b0, -1, 0, 1'b0, 1'b0);
    $display("[TB] num_limbs=4 lim=10 diverge at third check");
    applyStimulus(4, 1'b1, 10, 1'b0, 2, 1, 1'b0, 1'b0);
    $display("[TB] num_limbs=1 lim=0 abs mode");
    applyStimulus(1, 1'b1, 0, 1'b1, -1, 0, 1'b0, 1'b0);
    $display("[TB] num_limbs=3 index trace");
    applyStimulus(3, 1'b1, 1, 1'b0, -1, 2, 1'b0, 1'b0);
    $display("[TB] abs mode with forced signs re=1 im=0");
    applyStimulus(3, 1'b1, 2, 1'b1, -1, 0, 1'b0, 1'b1);
    $display("[TB] result held 50 cycles with start pulses");
    applyStimulus(2, 1'b1, 1, 1'b1, 1, 50, 1'b0, 1'b0);
    $display("[TB] num_limbs written as zero");
    applyStimulus(0, 1'b1, 1, 1'b1, -1, 0, 1'b0, 1'b0);
    $display("[TB] largest limb count");
    applyStimulus(63, 1'b1, 0, 1'b0, -1, 0, 1'b0, 1'b0);
    $display("[TB] reset during ITER_FLUSH then clean solve");
    applyStimulus(2, 1'b1, 3, 1'b1, -1, 0, 1'b1, 1'b0);
    applyStimulus(2, 1'b1, 2, 1'b1, -1, 1, 1'b0, 1'b0);
    $display("[TB] randomized solves");
    for (int t = 0; t < 25; t++) begin
      int lim;
      int divAt;
      lim   = int'($urandom_range(0, 4));
      divAt = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, lim));
      applyStimulus(int'($urandom_range(0, 8)), 1'b1, lim, 1'($urandom_range(0, 1)), divAt,
                    int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end
    repeat (2) @(negedge clock);
    checkOutput("stepQueueDrained", 64'(expStepQ.size()), 0);
    checkOutput("resultQueueDrained", 64'(expResQ.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
